// File: rtl/simple_dualportram_arbiter.sv
// Round-robin arbiter sharing one RAM access port between two req/done requesters.
// Each grant becomes a single write or read; out-of-range addresses complete with err and never reach the RAM.
module simple_dualportram_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [31:0]      mem_address,
  output logic [WIDTH-1:0] mem_din,
  output logic             mem_we,
  output logic             mem_oe,
  input  logic [WIDTH-1:0] mem_dout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  // Never let an address past the physical RAM through, even if WORDS is misconfigured.
  localparam logic [63:0] RAM_SPAN = 64'd1 << DEPTH;
  localparam logic [63:0] LIMIT    = (64'(WORDS) < RAM_SPAN) ? 64'(WORDS) : RAM_SPAN;

  function automatic logic addr_in_range(input logic [31:0] a);
    return {32'd0, a} < LIMIT;
  endfunction

  logic [1:0]       state;
  logic             last;
  logic             gnt_port;
  logic             gnt_we;
  logic             gnt_oor;

  logic             elig0;
  logic             elig1;
  logic             pick;
  logic             pick_we;
  logic             pick_ok;
  logic [31:0]      pick_addr;
  logic [WIDTH-1:0] pick_wdata;

  // A requester still showing done is lowering req, so it must not be re-granted yet.
  always_comb begin
    elig0      = req0 && !done0;
    elig1      = req1 && !done1;
    pick       = (elig0 && elig1) ? !last : elig1;
    pick_we    = pick ? we1 : we0;
    pick_addr  = pick ? addr1 : addr0;
    pick_wdata = pick ? wdata1 : wdata0;
    pick_ok    = addr_in_range(pick_addr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last        <= 1'b1;
      gnt_port    <= 1'b0;
      gnt_we      <= 1'b0;
      gnt_oor     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      mem_address <= '0;
      mem_din     <= '0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
    end else begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      mem_we <= 1'b0;
      mem_oe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (elig0 || elig1) begin
            gnt_port    <= pick;
            gnt_we      <= pick_we;
            gnt_oor     <= !pick_ok;
            last        <= pick;
            mem_address <= pick_addr;
            mem_din     <= pick_wdata;
            mem_we      <= pick_we && pick_ok;
            mem_oe      <= !pick_we && pick_ok;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!gnt_oor && !gnt_we) begin
            state <= S_RDWAIT;
          end else begin
            state <= S_IDLE;
            if (gnt_port) begin
              done1 <= 1'b1;
              err1  <= gnt_oor;
            end else begin
              done0 <= 1'b1;
              err0  <= gnt_oor;
            end
          end
        end
        S_RDWAIT: begin
          state <= S_IDLE;
          if (gnt_port) begin
            rdata1 <= mem_dout;
            done1  <= 1'b1;
          end else begin
            rdata0 <= mem_dout;
            done0  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_dualportram_arbiter.sv
// Bench for simple_dualportram_arbiter: behavioural RAM, transaction-level reference model,
// directed scenarios followed by randomized single-port transactions.
module tb_simple_dualportram_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        done0, done1, err0, err1;
  logic [31:0] mem_address, mem_din, mem_dout;
  logic        mem_we, mem_oe;

  int errors = 0;
  int checks = 0;

  simple_dualportram_arbiter #(.WIDTH(32), .DEPTH(10), .WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_din(mem_din), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [9:0] a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // RAM port b: registered read, unwritten words read back as init_word(address)
  logic [31:0] ram [0:1023];
  logic        wr  [0:1023];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) wr[i] <= 1'b0;
    end else begin
      if (mem_we) begin
        ram[mem_address[9:0]] <= mem_din;
        wr[mem_address[9:0]]  <= 1'b1;
      end
      if (mem_oe) mem_dout <= wr[mem_address[9:0]] ? ram[mem_address[9:0]] : init_word(mem_address[9:0]);
    end
  end

  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rdata [0:1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One complete requester transaction on port p, checked against the reference model.
  task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        oor, got, addr_ok, quiet;
    int          exp_lat, cycles, acc;
    logic [31:0] exp_rd, exp_other;
    oor       = (a >= 32'd1024);
    exp_lat   = (w || oor) ? 2 : 3;
    exp_rd    = (w || oor) ? ref_rdata[p] : ref_mem[a[9:0]];
    exp_other = ref_rdata[1-p];
    @(posedge clk); #1;
    drive(p, 1'b1, w, a, d);
    cycles = 0; acc = 0; got = 1'b0; addr_ok = 1'b1; quiet = 1'b1;
    while (!got && cycles < 12) begin
      @(posedge clk); cycles++;
      @(negedge clk);
      if (mem_we || mem_oe) begin
        acc++;
        if (mem_address !== a || mem_we !== w || (w && mem_din !== d)) addr_ok = 1'b0;
      end
      if (p == 0) begin
        if ((done1 | err1) !== 1'b0 || rdata1 !== exp_other) quiet = 1'b0;
        got = done0;
      end else begin
        if ((done0 | err0) !== 1'b0 || rdata0 !== exp_other) quiet = 1'b0;
        got = done1;
      end
    end
    chk($sformatf("p%0d_done_seen a=%0h", p, a), got, 1'b1);
    chk($sformatf("p%0d_latency a=%0h", p, a), cycles, exp_lat);
    chk($sformatf("p%0d_err a=%0h", p, a), (p == 0) ? err0 : err1, oor);
    chk($sformatf("p%0d_rdata a=%0h", p, a), (p == 0) ? rdata0 : rdata1, exp_rd);
    chk($sformatf("p%0d_ram_accesses a=%0h", p, a), acc, oor ? 0 : 1);
    chk($sformatf("p%0d_ram_signals a=%0h", p, a), addr_ok, 1'b1);
    chk($sformatf("p%0d_other_port_quiet a=%0h", p, a), quiet, 1'b1);
    // req is still high at this edge; the done mask must prevent a second grant
    @(posedge clk); #1;
    drive(p, 1'b0, w, a, d);
    chk($sformatf("p%0d_done_one_cycle", p), (p == 0) ? {done0, err0} : {done1, err1}, 2'b00);
    @(negedge clk);
    chk($sformatf("p%0d_no_regrant", p), {mem_we, mem_oe}, 2'b00);
    if (!oor && w)  ref_mem[a[9:0]] = d;
    if (!oor && !w) ref_rdata[p] = ref_mem[a[9:0]];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        quiet;
    logic [31:0] cw0, cw1, a, d;
    logic        w;
    int          p, r, c;

    reset = 1'b0; ram_clr = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    ref_rdata[0] = 0; ref_rdata[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_outputs", {rdata0, rdata1, done0, done1, err0, err1}, '0);
    chk("por_mem", {mem_address, mem_din, mem_we, mem_oe}, '0);
    reset = 1'b1; ram_clr = 1'b0;

    // Reset asserted while a read sits in RDWAIT
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'd3, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0; #1;
    chk("rst_rdata", {rdata0, rdata1}, '0);
    chk("rst_done_err", {done0, done1, err0, err1}, 4'b0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_din_we_oe", {mem_din, mem_we, mem_oe}, '0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); reset = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if ((done0 | done1 | mem_we | mem_oe) !== 1'b0) quiet = 1'b1 & 1'b0;
    end
    chk("rst_dropped_txn_no_done", quiet, 1'b1);

    // Contention right after reset: tie goes to port 0, then strict alternation
    cw0 = $urandom; cw1 = $urandom;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'd1, cw0);
    drive(1, 1'b1, 1'b1, 32'd2, cw1);
    for (c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 7) drive(0, 1'b0, 1'b1, 32'd1, cw0);
      if (c == 9) drive(1, 1'b0, 1'b1, 32'd2, cw1);
      @(negedge clk);
      chk($sformatf("tie_done0 c=%0d", c), done0, (c % 2 == 0) && (c <= 8) && ((c / 2) % 2 == 1));
      chk($sformatf("tie_done1 c=%0d", c), done1, (c % 2 == 0) && (c <= 8) && ((c / 2) % 2 == 0));
      chk($sformatf("tie_mem_we c=%0d", c), mem_we, (c % 2 == 1) && (c <= 7));
      if (mem_we) chk($sformatf("tie_order c=%0d", c), mem_address, (c % 4 == 1) ? 32'd1 : 32'd2);
    end
    ref_mem[1] = cw0; ref_mem[2] = cw1;

    // Directed single transactions
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'd5, 32'd0);
    txn(1, 1'b0, 32'd1024, 32'd0);
    txn(1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    txn(0, 1'b1, 32'd2000, 32'h1111_2222);
    txn(0, 1'b1, 32'd7, 32'h0000_CAFE);
    txn(0, 1'b0, 32'd7, 32'd0);
    txn(1, 1'b0, 32'h1234, 32'd0);
    txn(1, 1'b0, 32'd1, 32'd0);
    txn(0, 1'b0, 32'd2, 32'd0);
    txn(1, 1'b0, 32'd1023, 32'd0);

    for (int i = 0; i < 40; i++) begin
      p = $urandom % 2;
      w = 1'($urandom % 2);
      r = $urandom % 10;
      if (r == 0)      a = 32'd1024 + ($urandom % 4096);
      else if (r == 1) a = 32'hFFFF_FFF0 | ($urandom % 16);
      else             a = $urandom % 16;
      d = $urandom;
      txn(p, w, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simple_dualportram_arbiter.md
# simple_dualportram_arbiter

Two-requester round-robin arbiter that shares one `simple_dualportram` access port (address/din/we/oe/dout) between two independent masters. It sequences each granted request as a single RAM write or read, returns read data with a one-cycle completion pulse, and rejects out-of-range addresses without touching memory. It sits between generated method datapaths and a shared RAM instance; each requester sees a simple req/done handshake.

## Interface
Parameters:
- WIDTH, 32, data word width; must match the RAM
- DEPTH, 10, RAM address bits; must match the RAM
- WORDS, 1024, RAM word count; addresses >= WORDS are out of range

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- req0, req1  in  1  request from port 0 / port 1; held high until done
- we0, we1  in  1  1 = write, 0 = read; stable while req is high
- addr0, addr1  in  32  word address; stable while req is high
- wdata0, wdata1  in  WIDTH  write data; stable while req is high
- rdata0, rdata1  out  WIDTH  read data; registered, valid in the done cycle, held until the next read on that port
- done0, done1  out  1  one-cycle completion pulse
- err0, err1  out  1  one-cycle pulse, coincident with done, when the address is out of range
- mem_address  out  32  to RAM `address_b`
- mem_din  out  WIDTH  to RAM `din_b`
- mem_we  out  1  to RAM `we_b`
- mem_oe  out  1  to RAM `oe_b`
- mem_dout  in  WIDTH  from RAM `dout_b`; valid one cycle after the address edge

## Operation
- FSM states: IDLE, ISSUE, RDWAIT. All outputs are registered.
- IDLE: eligible request = req_i && !done_i. The mask blocks re-grant while the requester is still lowering req.
  - Select with a round-robin pointer `last`: prefer the port != `last`.
  - A single eligible port wins outright.
  - On grant: latch port id, we, addr, wdata; drive mem_address = addr and mem_din = wdata; set `last` = granted port; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - In range (addr < WORDS), write: mem_we = 1 for this cycle only. Next edge: done = 1, go to IDLE.
  - In range, read: mem_oe = 1 for this cycle. Go to RDWAIT.
  - Out of range: mem_we = mem_oe = 0. Next edge: done = 1, err = 1, rdata unchanged, go to IDLE.
- RDWAIT: at the edge leaving it, rdata_granted <= mem_dout; done = 1; go to IDLE.
- Range compare uses the full 32-bit addr, unsigned. Only addr[DEPTH-1:0] is meaningful to the RAM.
- Only the granted port's done/err/rdata change. The other port's outputs hold.
- Reset (async assert, any state): state = IDLE, `last` = 1 (port 0 wins the first tie). All outputs are 0: rdata*, done*, err*, mem_*. An in-flight transaction is dropped with no done; requesters must re-issue.

## Timing
- Edge E0: req sampled in IDLE, grant taken. Edge E1: ISSUE ends.
- Write latency: req high before E0, RAM written at E1, done high in the cycle after E1. That is 2 cycles from sampling.
- Read latency: RAM registers data at E1, captured at E2, done and rdata valid in the cycle after E2. That is 3 cycles.
- Requester rule: hold req/we/addr/wdata until done is seen; req may drop at the edge ending the done cycle.
- Re-grant to the same port is blocked in its done cycle.
- Throughput:
  - Back-to-back alternating ports give one write per 2 cycles and one read per 3 cycles.
  - A single port must show req low, or be masked by done, for at least one cycle between transactions.
- Simultaneous req0 and req1 in IDLE: the grant alternates strictly. The loser waits and is served next with no gap beyond the IDLE cycle.

## Test plan
- Reset: hold reset = 0 mid-read (state RDWAIT) -> all outputs 0 immediately; after release, state IDLE, no done. The next tie grants port 0.
- Single write/read:
  - Port0 writes addr 5 = 0xDEADBEEF -> mem_we high exactly one cycle with mem_address 5; done0 2 cycles after the sampling edge.
  - Port0 then reads addr 5 -> rdata0 = 0xDEADBEEF with done0, 3 cycles after sampling.
- Contention: req0 and req1 both held continuously, writing addrs 1 and 2 -> grant order 0,1,0,1. Each done pulses once per transaction; no port is served twice in a row.
- Out of range: port1 reads addr 1024 (WORDS = 1024) -> mem_oe and mem_we stay 0; done1 = err1 = 1 for one cycle; rdata1 unchanged. Addr 0xFFFF_FFFF behaves the same way.
- Handshake mask: port0 keeps req0 high in its done cycle and drops it at the following edge -> exactly one RAM access, no duplicate grant.
- Isolation: port1 reads 0x1234 while rdata0 holds 0xCAFE -> rdata0 stays 0xCAFE; done0 and err0 stay 0 throughout.
